// File: rtl/icache_rom_responder.sv
// Instruction-bus responder: serves fetch reads from a loader-filled RAM, returning
// tag-echoed responses in order under a bounded in-flight credit limit.
module icache_rom_responder #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned QUEUE_SIZE = 4,
  parameter logic [DATA_WIDTH-1:0] OOB_DATA = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]         rsp_tag,
  input  logic                         load_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  output logic [31:0]                  req_count,
  output logic [15:0]                  oob_count
);

  localparam int unsigned MemAw = $clog2(MEM_DEPTH);
  localparam int unsigned PtrW  = $clog2(QUEUE_SIZE);
  localparam int unsigned CntW  = $clog2(QUEUE_SIZE + 1);
  localparam logic [CntW-1:0] QueueMax = CntW'(QUEUE_SIZE);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

  logic                  req_fire, rsp_fire, req_oob, push;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic                  s1_valid_q, s1_oob_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;
  logic [DATA_WIDTH-1:0] s1_rdata_q, push_data;

  logic [DATA_WIDTH-1:0] fifo_data_q [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  fifo_tag_q  [QUEUE_SIZE];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [31:0]           req_count_q;
  logic [15:0]           oob_count_q;

  // Ready depends only on registered credits and the loader, never on rsp_ready.
  assign req_ready = reset_n && !load_valid && (outstanding_q < QueueMax);
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign req_oob   = ((req_addr >> MemAw) != '0);
  assign push      = s1_valid_q;
  assign push_data = s1_oob_q ? OOB_DATA : s1_rdata_q;
  assign rsp_data  = fifo_data_q[rd_ptr_q];
  assign rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign req_count = req_count_q;
  assign oob_count = oob_count_q;

  // RAM and datapath registers are not reset; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (load_valid) begin
      ram[load_addr] <= load_data;
    end
    if (req_fire) begin
      s1_rdata_q <= ram[req_addr[MemAw-1:0]];
      s1_tag_q   <= req_tag;
      s1_oob_q   <= req_oob;
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_tag_q[wr_ptr_q]  <= s1_tag_q;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, rsp_fire})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntOne;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntOne;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      s1_valid_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      req_count_q   <= '0;
      oob_count_q   <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      s1_valid_q    <= req_fire;
      fifo_cnt_q    <= fifo_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rsp_fire) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (req_fire) begin
        req_count_q <= req_count_q + 32'd1;
        if (req_oob && (oob_count_q != 16'hFFFF)) begin
          oob_count_q <= oob_count_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_rom_responder.sv
// Bench for icache_rom_responder: directed table, hand sequences and random traffic
// checked against a timestamped response-queue model.
module tb_icache_rom_responder;

  localparam logic [31:0] Oob = 32'h00000013;

  logic        clk, reset_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, load_valid;
  logic [29:0] req_addr;
  logic [7:0]  req_tag, rsp_tag;
  logic [31:0] rsp_data, load_data, req_count;
  logic [11:0] load_addr;
  logic [15:0] oob_count;

  icache_rom_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .load_valid(load_valid),
    .load_addr (load_addr),
    .load_data (load_data),
    .req_count (req_count),
    .oob_count (oob_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
    int unsigned due;
  } ent_t;

  typedef struct packed {
    int unsigned t;
    logic [7:0]  tag;
    logic [31:0] data;
  } log_t;

  typedef struct packed {
    logic        rv;
    logic [29:0] ra;
    logic [7:0]  rt;
    logic        lv;
    logic [11:0] la;
    logic [31:0] ld;
    logic        rr;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [7:0]  e_tag;
  } vec_t;

  int unsigned n_cmp = 0, n_bad = 0, now = 0;
  logic [31:0] mram [4096];
  ent_t        mq[$];
  log_t        rlog[$];
  int unsigned m_out, m_req, acc_cnt;
  logic [15:0] m_oob;
  logic        last_rdy, last_vld;
  logic [31:0] last_data;
  logic [7:0]  last_tag;
  vec_t        tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, now);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input logic rv, input logic [29:0] ra, input logic [7:0] rt,
                     input logic lv, input logic [11:0] la, input logic [31:0] ld,
                     input logic rr);
    logic exp_rdy, exp_vld;
    ent_t e;
    req_valid = rv; req_addr = ra; req_tag = rt;
    load_valid = lv; load_addr = la; load_data = ld; rsp_ready = rr;
    #1;
    last_rdy = req_ready; last_vld = rsp_valid; last_data = rsp_data; last_tag = rsp_tag;
    exp_rdy = (m_out < 4) && !lv;
    exp_vld = (mq.size() != 0) && (mq[0].due <= now);
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_vld);
    if (exp_vld) begin
      chk("rsp_data", rsp_data, mq[0].data);
      chk("rsp_tag", rsp_tag, mq[0].tag);
    end
    chk("req_count", req_count, m_req);
    chk("oob_count", oob_count, m_oob);
    if (rsp_valid && rr) rlog.push_back('{t: now, tag: rsp_tag, data: rsp_data});
    if (rv && req_ready) acc_cnt++;
    if (lv) mram[la] = ld;
    if (rv && exp_rdy) begin
      e.data = (ra >= 30'd4096) ? Oob : mram[ra[11:0]];
      e.tag  = rt;
      e.due  = now + 2;
      mq.push_back(e);
      m_out++;
      m_req++;
      if (ra >= 30'd4096 && m_oob != 16'hFFFF) m_oob++;
    end
    if (exp_vld && rr) begin
      void'(mq.pop_front());
      m_out--;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, rr);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; load_valid = 1'b0; rsp_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    mq.delete(); m_out = 0; m_req = 0; m_oob = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    now += 3;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_tag = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; rsp_ready = 1'b0;
    m_out = 0; m_req = 0; m_oob = 16'h0; acc_cnt = 0;
    last_rdy = 1'b0; last_vld = 1'b0; last_data = '0; last_tag = '0;

    tbl[0] = '{1'b1, 30'h10, 8'h5A, 1'b1, 12'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0};
    tbl[1] = '{1'b1, 30'h10, 8'h5A, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};
    tbl[2] = '{1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};
    tbl[3] = '{1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 8'h5A};
    tbl[4] = '{1'b1, 30'h20, 8'h11, 1'b1, 12'h20, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0};
    tbl[5] = '{1'b1, 30'h20, 8'h11, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};
    tbl[6] = '{1'b1, 30'h3FFFF000, 8'h22, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};
    tbl[7] = '{1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h12345678, 8'h11};
    tbl[8] = '{1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b1, Oob, 8'h22};
    tbl[9] = '{1'b0, 30'h0, 8'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'h0};

    do_reset();
    chk("reset_req_count", req_count, 0);
    chk("reset_oob_count", oob_count, 0);

    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 30'h0, 8'h0, 1'b1, i[11:0], $urandom, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rv, tbl[i].ra, tbl[i].rt, tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].rr);
      chk("tbl_ready", last_rdy, tbl[i].e_rdy);
      chk("tbl_valid", last_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk("tbl_data", last_data, tbl[i].e_data);
        chk("tbl_tag", last_tag, tbl[i].e_tag);
      end
    end
    chk("tbl_req_count", req_count, 3);
    chk("tbl_oob_count", oob_count, 1);

    // Back-to-back 8 requests: responses on consecutive cycles from fire+2.
    do_reset();
    rlog.delete();
    begin
      int unsigned base;
      base = now;
      for (int i = 0; i < 8; i++) cyc(1'b1, 30'(i), 8'(i), 1'b0, 12'h0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("b2b_rsp_cnt", rlog.size(), 8);
      for (int i = 0; i < 8 && i < rlog.size(); i++) begin
        chk("b2b_tag", rlog[i].tag, 8'(i));
        chk("b2b_time", rlog[i].t, base + 2 + i);
      end
      chk("b2b_req_count", req_count, 8);
    end

    // Backpressure: only four credits.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 30'h40 + 30'(i), 8'hA0 + 8'(i), 1'b0, 12'h0, 32'h0, 1'b0);
    chk("bp_accepted", acc_cnt, 4);
    idle(1'b0);
    chk("bp_ready_full", last_rdy, 0);
    idle(1'b1);
    chk("bp_ready_first_fire", last_rdy, 0);
    idle(1'b1);
    chk("bp_ready_after", last_rdy, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_drained", last_vld, 0);

    // Reset with queued responses, RAM must survive.
    for (int i = 0; i < 3; i++) cyc(1'b1, 30'(i), 8'(i), 1'b0, 12'h0, 32'h0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    chk("post_rst_req_count", req_count, 0);
    chk("post_rst_oob_count", oob_count, 0);
    rlog.delete();
    cyc(1'b1, 30'h10, 8'h77, 1'b0, 12'h0, 32'h0, 1'b1);
    chk("post_rst_ready", last_rdy, 1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("post_rst_rsp_cnt", rlog.size(), 1);
    if (rlog.size() > 0) chk("post_rst_data", rlog[0].data, 32'hDEADBEEF);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [29:0] a;
      a = ($urandom_range(0, 9) == 0) ? (30'h3FFFF000 | 30'($urandom_range(0, 4095)))
                                      : 30'($urandom_range(0, 127));
      cyc(1'($urandom_range(0, 3) != 0), a, 8'($urandom),
          1'($urandom_range(0, 4) == 0), 12'($urandom_range(0, 127)), $urandom,
          1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);

    // OOB counter saturation.
    do_reset();
    for (int i = 0; i < 65540; i++) cyc(1'b1, 30'h3FFFF000, i[7:0], 1'b0, 12'h0, 32'h0, 1'b1);
    chk("oob_saturated", oob_count, 16'hFFFF);
    chk("oob_req_count", req_count, 65540);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_rom_responder.md
Name: icache_rom_responder

Overview:
- Responder end of the instruction-cache memory bus. Sits where the icache would sit, e.g. in bring-up or L1-less configurations.
- Accepts word-address read requests carrying an opaque tag (uuid + warp id) from the fetch stage.
- Reads a local instruction RAM, preloaded through a loader write port.
- Returns in-order responses with the tag echoed unchanged. Bounded in-flight credits provide backpressure.

Parameters:
ADDR_WIDTH, 30, request word-address width
TAG_WIDTH, 8, request/response tag width (uuid + wid), opaque
DATA_WIDTH, 32, instruction word width
MEM_DEPTH, 4096, RAM words; power of two
QUEUE_SIZE, 4, max outstanding requests (in pipe + response queue); power of two, >=2
OOB_DATA, 32'h00000013, data returned for out-of-range addresses (NOP)

Ports:
clk  in  1  clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_addr  in  ADDR_WIDTH  word address
req_tag  in  TAG_WIDTH  request tag
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_WIDTH  instruction word
rsp_tag  out  TAG_WIDTH  echoed tag
load_valid  in  1  loader write strobe
load_addr  in  log2(MEM_DEPTH)  loader word address
load_data  in  DATA_WIDTH  loader word
req_count  out  32  accepted requests, wrapping
oob_count  out  16  out-of-range requests, saturating at 16'hFFFF

Behaviour:
- Reset values: req_ready=0 while reset_n=0. rsp_valid=0, credit count=0, queue empty, read stage empty, req_count=0, oob_count=0.
- rsp_data and rsp_tag are don't-care while rsp_valid=0.
- RAM contents are not reset and survive reset.
- Reset asserted mid-operation drops all in-flight and queued responses immediately.
- Credits: counter `outstanding` in 0..QUEUE_SIZE.
  - Increments on req fire; decrements on rsp fire (rsp_valid&&rsp_ready).
  - Both in the same cycle: counter unchanged.
- req_ready = (outstanding < QUEUE_SIZE) && !load_valid. The loader has priority and stalls requests for that cycle.
- Pipeline:
  - Cycle N, req fire: RAM read issued. Address, tag and oob flag are captured into stage S1.
  - Cycle N+1: S1 holds the RAM read data. Entry {data, tag} is pushed into the response FIFO (depth QUEUE_SIZE).
  - rsp_data = OOB_DATA if the oob flag is set, otherwise RAM data.
  - rsp_valid reflects FIFO non-empty from a registered output. Minimum latency is 2 cycles: fire at N gives rsp_valid at N+2.
- Credit accounting guarantees the FIFO never overflows. S1 never stalls: no push without space.
- Ordering: responses in strict request order. rsp_data and rsp_tag stay stable while rsp_valid && !rsp_ready.
- Out-of-range: req_addr >= MEM_DEPTH (upper bits nonzero) does not index RAM. It returns OOB_DATA and increments oob_count on accept.
- Loader write: on load_valid, RAM[load_addr] <= load_data at the clock edge.
  - A request accepted in a later cycle to the same address sees the new data.
  - Because load_valid blocks req_ready, no same-cycle read/write collision occurs.
- Throughput: one request per cycle when rsp_ready stays high.
  - At full credits with a simultaneous rsp fire, req_ready stays 0 that cycle. Credits free the cycle after. ready is not combinationally dependent on rsp_ready.
- req_count increments by 1 per req fire and wraps at 2^32.
- No state machine beyond the credit counter and S1 valid bit. Both are sequential and resettable.

Test Plan:
- Load RAM[0x10]=0xDEADBEEF. Request addr 0x10, tag 0x5A at cycle N with rsp_ready=1 -> rsp_valid at N+2 with data 0xDEADBEEF, tag 0x5A. req_count=1.
- Back-to-back 8 requests, addr 0..7, tags 0..7, rsp_ready=1 -> 8 in-order responses on consecutive cycles, no bubbles after the first. req_count=8.
- rsp_ready=0, issue 6 requests -> exactly 4 accepted, req_ready=0 afterward. rsp_data/rsp_tag hold stable. Raise rsp_ready -> 4 responses drain; req_ready returns one cycle after the first rsp fire.
- Request addr 0x3FFFF000 with MEM_DEPTH=4096 -> rsp_data=0x00000013. oob_count=1. Force 65536 OOB requests -> oob_count holds at 0xFFFF.
- Assert load_valid concurrently with req_valid -> req_ready=0 that cycle. Next cycle the request to the same address returns the newly loaded word.
- Drop reset_n with 3 responses queued -> rsp_valid=0 and req_ready=0 immediately. After release: outstanding=0, counters=0, previously loaded RAM data still returned.
